// File: rtl/gtx_reset_seq_if.sv
// Status/control bundle between the GTX reset sequencer and the transceiver,
// user-clock MMCMs and MAC. The sequencer takes the master side.
interface gtx_reset_seq_if;
    logic       restart;
    logic       cpll_locked;
    logic       tx_resetdone;
    logic       rx_resetdone;
    logic       tx_usrclk_rdy;
    logic       rx_usrclk_rdy;
    logic       cpll_reset;
    logic       gt_txreset;
    logic       gt_rxreset;
    logic       mac_reset;
    logic       link_ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [2:0] state_mon;

    modport master (
        input  restart, cpll_locked, tx_resetdone, rx_resetdone,
               tx_usrclk_rdy, rx_usrclk_rdy,
        output cpll_reset, gt_txreset, gt_rxreset, mac_reset,
               link_ready, fault, retry_cnt, state_mon
    );

    modport slave (
        output restart, cpll_locked, tx_resetdone, rx_resetdone,
               tx_usrclk_rdy, rx_usrclk_rdy,
        input  cpll_reset, gt_txreset, gt_rxreset, mac_reset,
               link_ready, fault, retry_cnt, state_mon
    );
endinterface

// File: rtl/gtx_reset_seq.sv
// Kintex-7 GTX reset sequencer (DRP clock domain).
// Pulses CPLL reset, waits for lock, pulses GTX TX/RX reset, waits for
// reset-done and user-clock lock, then releases the MAC. Timeouts and lock
// loss retry the whole sequence a bounded number of times before latching
// a sticky fault that only restart or reset_n clears.
module gtx_reset_seq #(
    parameter int PLL_DELAY = 60,
    parameter int PULSE_LEN = 8,
    parameter int TIMEOUT   = 65535,
    parameter int MAX_RETRY = 3,
    parameter int CW        = 16
) (
    input  logic            drp_clk,
    input  logic            reset_n,
    gtx_reset_seq_if.master bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLL_RST  = 3'd1,
        PLL_WAIT = 3'd2,
        GT_RST   = 3'd3,
        GT_WAIT  = 3'd4,
        RUN      = 3'd5,
        FAULT    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          fail_c;

    // Synchronizer bits: {cpll_locked, tx_resetdone, rx_resetdone, tx_usrclk_rdy, rx_usrclk_rdy}
    logic [4:0]    sync1_q, sync2_q;
    logic          lock_s;
    logic          gt_ok_s;

    // Output register: {cpll_reset, gt_txreset, gt_rxreset, mac_reset, link_ready, fault}
    logic [5:0]    out_q;

    // Per-state output levels; every state not releasing a reset keeps it asserted.
    function automatic logic [5:0] decode(state_t s);
        logic [5:0] o;
        case (s)
            IDLE:     o = 6'b011100;
            PLL_RST:  o = 6'b111100;
            PLL_WAIT: o = 6'b011100;
            GT_RST:   o = 6'b011100;
            GT_WAIT:  o = 6'b000100;
            RUN:      o = 6'b000010;
            FAULT:    o = 6'b011101;
            default:  o = 6'b011100;
        endcase
        return o;
    endfunction

    // Two-flop synchronizers for the asynchronous GTX/MMCM status inputs.
    always_ff @(posedge drp_clk) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.cpll_locked, bus.tx_resetdone, bus.rx_resetdone,
                        bus.tx_usrclk_rdy, bus.rx_usrclk_rdy};
            sync2_q <= sync1_q;
        end
    end

    assign lock_s  = sync2_q[4];
    assign gt_ok_s = &sync2_q[3:0];

    // Next-state, retry bookkeeping and shared-counter update.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fail_c  = 1'b0;
        if (bus.restart) begin
            state_d = IDLE;
            retry_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_q == CW'(PLL_DELAY - 1)) state_d = PLL_RST;
                end
                PLL_RST: begin
                    if (cnt_q == CW'(PULSE_LEN - 1)) state_d = PLL_WAIT;
                end
                PLL_WAIT: begin
                    if (lock_s)                        state_d = GT_RST;
                    else if (cnt_q == CW'(TIMEOUT - 1)) fail_c  = 1'b1;
                end
                GT_RST: begin
                    if (!lock_s)                          fail_c  = 1'b1;
                    else if (cnt_q == CW'(PULSE_LEN - 1)) state_d = GT_WAIT;
                end
                GT_WAIT: begin
                    if (!lock_s)                        fail_c  = 1'b1;
                    else if (gt_ok_s)                   state_d = RUN;
                    else if (cnt_q == CW'(TIMEOUT - 1)) fail_c  = 1'b1;
                end
                RUN: begin
                    // Only CPLL lock loss matters here; resetdone/usrclk glitches are ignored.
                    if (!lock_s) fail_c = 1'b1;
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            // A failure is resolved in the same cycle: retry from IDLE or give up.
            if (fail_c) begin
                if (retry_q == 4'(MAX_RETRY - 1)) begin
                    state_d = FAULT;
                    retry_d = 4'(MAX_RETRY);
                end else begin
                    state_d = IDLE;
                    retry_d = retry_q + 4'd1;
                end
            end
        end
        // Restart always re-times IDLE from zero, even when already in IDLE.
        if ((state_d != state_q) || bus.restart) cnt_d = '0;
        else                                     cnt_d = cnt_q + CW'(1);
    end

    // State, counter, retry and registered outputs (outputs track the next state).
    always_ff @(posedge drp_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            out_q   <= decode(IDLE);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            out_q   <= decode(state_d);
        end
    end

    assign bus.cpll_reset = out_q[5];
    assign bus.gt_txreset = out_q[4];
    assign bus.gt_rxreset = out_q[3];
    assign bus.mac_reset  = out_q[2];
    assign bus.link_ready = out_q[1];
    assign bus.fault      = out_q[0];
    assign bus.retry_cnt  = retry_q;
    assign bus.state_mon  = state_q;

endmodule

// File: tb/tb_gtx_reset_seq.sv
// Bench for gtx_reset_seq: directed bring-up/failure scenarios followed by a
// random soak, with a per-cycle expected-response queue drained by a monitor.
module tb_gtx_reset_seq;
    localparam int PLL_DELAY = 4;
    localparam int PULSE_LEN = 3;
    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 2;

    localparam int S_IDLE = 0, S_PLL_RST = 1, S_PLL_WAIT = 2, S_GT_RST = 3;
    localparam int S_GT_WAIT = 4, S_RUN = 5, S_FAULT = 6;

    logic clk = 1'b0;
    logic reset_n;

    gtx_reset_seq_if bif();

    gtx_reset_seq #(
        .PLL_DELAY (PLL_DELAY),
        .PULSE_LEN (PULSE_LEN),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY),
        .CW        (16)
    ) dut (
        .drp_clk (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       st;
        bit [5:0] outs;
        int       retry;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // {cpll_reset, gt_txreset, gt_rxreset, mac_reset, link_ready, fault} per state
    bit [5:0] out_tab [0:6] = '{6'b011100, 6'b111100, 6'b011100, 6'b011100,
                                6'b000100, 6'b000010, 6'b011101};

    // Reference model: phase, time spent in phase, retry count, and a
    // two-deep delay line standing in for the input synchronizers.
    int       m_state = S_IDLE;
    int       m_elapsed = 0;
    int       m_retry = 0;
    bit       h1_lock = 0, h2_lock = 0;
    bit [3:0] h1_st = 0, h2_st = 0;

    function automatic void model_step(bit rstn, bit rst_req, bit lock, bit [3:0] st);
        bit   seen_lock;
        bit   all_ok;
        bit   fail;
        int   nxt;
        exp_t e;
        if (!rstn) begin
            m_state = S_IDLE; m_elapsed = 0; m_retry = 0;
            h1_lock = 0; h2_lock = 0; h1_st = 0; h2_st = 0;
        end else begin
            seen_lock = h2_lock;
            all_ok    = (h2_st == 4'hF);
            h2_lock = h1_lock; h1_lock = lock;
            h2_st   = h1_st;   h1_st   = st;
            nxt  = m_state;
            fail = 0;
            if (rst_req) begin
                nxt = S_IDLE;
                m_retry = 0;
            end else begin
                case (m_state)
                    S_IDLE:     if (m_elapsed + 1 == PLL_DELAY) nxt = S_PLL_RST;
                    S_PLL_RST:  if (m_elapsed + 1 == PULSE_LEN) nxt = S_PLL_WAIT;
                    S_PLL_WAIT: if (seen_lock) nxt = S_GT_RST;
                                else if (m_elapsed + 1 == TIMEOUT) fail = 1;
                    S_GT_RST:   if (!seen_lock) fail = 1;
                                else if (m_elapsed + 1 == PULSE_LEN) nxt = S_GT_WAIT;
                    S_GT_WAIT:  if (!seen_lock) fail = 1;
                                else if (all_ok) nxt = S_RUN;
                                else if (m_elapsed + 1 == TIMEOUT) fail = 1;
                    S_RUN:      if (!seen_lock) fail = 1;
                    default:    nxt = m_state;
                endcase
                if (fail) begin
                    if (m_retry + 1 >= MAX_RETRY) begin
                        nxt = S_FAULT; m_retry = MAX_RETRY;
                    end else begin
                        nxt = S_IDLE; m_retry = m_retry + 1;
                    end
                end
            end
            m_elapsed = (nxt != m_state || rst_req) ? 0 : m_elapsed + 1;
            m_state   = nxt;
        end
        e.st = m_state; e.outs = out_tab[m_state]; e.retry = m_retry;
        exp_q.push_back(e);
    endfunction

    // Monitor: every cycle the DUT presents a status word; compare it with the queued expectation.
    always @(negedge clk) begin
        exp_t     e;
        bit [5:0] outs;
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            outs = {bif.cpll_reset, bif.gt_txreset, bif.gt_rxreset,
                    bif.mac_reset, bif.link_ready, bif.fault};
            n_checks++;
            if (bif.state_mon !== 3'(e.st) || outs !== e.outs || bif.retry_cnt !== 4'(e.retry)) begin
                n_fail++;
                $display("FAIL cycle_status t=%0t: got state=%0d outs=%b retry=%0d, expected state=%0d outs=%b retry=%0d",
                         $time, bif.state_mon, outs, bif.retry_cnt, e.st, e.outs, e.retry);
            end
        end
    end

    int       cyc = 0;
    int       rise_cyc = -1;
    int       pulse_w = -1;
    bit       cpll_prev = 0;
    bit [3:0] cur_st = 0;

    task automatic set_status(input bit [3:0] st);
        cur_st = st;
        {bif.tx_resetdone, bif.rx_resetdone, bif.tx_usrclk_rdy, bif.rx_usrclk_rdy} = st;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(reset_n, bif.restart, bif.cpll_locked, cur_st);
        #1;
        if (!reset_n) cyc = 0;
        else          cyc++;
        if (bif.cpll_reset === 1'b1 && !cpll_prev) rise_cyc = cyc;
        if (bif.cpll_reset !== 1'b1 && cpll_prev)  pulse_w  = cyc - rise_cyc;
        cpll_prev = (bif.cpll_reset === 1'b1);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int i;
        i = 0;
        while (int'(bif.state_mon) != s && i < budget) begin
            tick();
            i++;
        end
        chk(name, int'(bif.state_mon), s);
    endtask

    task automatic time_in_state(input int s, input int budget, output int n);
        n = 0;
        while (int'(bif.state_mon) == s && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_restart();
        bif.restart = 1'b1;
        tick();
        bif.restart = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        bif.restart = 1'b0;
        bif.cpll_locked = 1'b0;
        set_status(4'h0);
        tick();
        tick();
        chk("reset_state", int'(bif.state_mon), S_IDLE);
        chk("reset_cpll_reset", int'(bif.cpll_reset), 0);
        chk("reset_gt_txreset", int'(bif.gt_txreset), 1);
        chk("reset_mac_reset", int'(bif.mac_reset), 1);
        chk("reset_link_ready", int'(bif.link_ready), 0);
        chk("reset_retry", int'(bif.retry_cnt), 0);

        // Nominal bring-up
        reset_n = 1'b1;
        wait_state(S_PLL_WAIT, 20, "nom_reach_pll_wait");
        chk("nom_cpll_rise_cycle", rise_cyc, PLL_DELAY);
        chk("nom_cpll_width", pulse_w, PULSE_LEN);
        repeat ($urandom_range(1, 3)) tick();
        bif.cpll_locked = 1'b1;
        wait_state(S_GT_WAIT, 20, "nom_reach_gt_wait");
        repeat ($urandom_range(2, 8)) tick();
        set_status(4'hF);
        wait_state(S_RUN, 10, "nom_reach_run");
        chk("nom_mac_reset", int'(bif.mac_reset), 0);
        chk("nom_link_ready", int'(bif.link_ready), 1);
        chk("nom_retry", int'(bif.retry_cnt), 0);

        // Lock loss in RUN
        repeat ($urandom_range(3, 12)) tick();
        bif.cpll_locked = 1'b0;
        set_status(4'h0);
        tick();
        bif.cpll_locked = 1'b1;
        tick();
        tick();
        chk("lockloss_state", int'(bif.state_mon), S_IDLE);
        chk("lockloss_mac_reset", int'(bif.mac_reset), 1);
        chk("lockloss_link_ready", int'(bif.link_ready), 0);
        chk("lockloss_retry", int'(bif.retry_cnt), 1);
        wait_state(S_GT_WAIT, 40, "lockloss_reach_gt_wait");
        repeat ($urandom_range(2, 8)) tick();
        set_status(4'hF);
        wait_state(S_RUN, 10, "lockloss_reach_run");
        chk("lockloss_run_retry", int'(bif.retry_cnt), 1);

        // rx_resetdone held low: GT_WAIT timeout, then recovery
        pulse_restart();
        chk("restart_state", int'(bif.state_mon), S_IDLE);
        chk("restart_retry", int'(bif.retry_cnt), 0);
        set_status(4'b1011);
        wait_state(S_GT_WAIT, 40, "rxdone_reach_gt_wait");
        time_in_state(S_GT_WAIT, 40, n);
        chk("rxdone_timeout_len", n, TIMEOUT);
        chk("rxdone_retry", int'(bif.retry_cnt), 1);
        wait_state(S_GT_WAIT, 40, "rxdone_reach_gt_wait2");
        repeat ($urandom_range(1, 6)) tick();
        set_status(4'hF);
        wait_state(S_RUN, 10, "rxdone_reach_run");
        chk("rxdone_run_retry", int'(bif.retry_cnt), 1);

        // Lock never asserts: two PLL_WAIT timeouts then FAULT
        bif.cpll_locked = 1'b0;
        set_status(4'h0);
        pulse_restart();
        wait_state(S_PLL_WAIT, 20, "nolock_reach_pll_wait");
        time_in_state(S_PLL_WAIT, 40, n);
        chk("nolock_timeout1_len", n, TIMEOUT);
        chk("nolock_retry1", int'(bif.retry_cnt), 1);
        wait_state(S_PLL_WAIT, 20, "nolock_reach_pll_wait2");
        time_in_state(S_PLL_WAIT, 40, n);
        chk("nolock_timeout2_len", n, TIMEOUT);
        chk("nolock_fault_state", int'(bif.state_mon), S_FAULT);
        chk("nolock_fault_flag", int'(bif.fault), 1);
        chk("nolock_gt_txreset", int'(bif.gt_txreset), 1);
        chk("nolock_retry2", int'(bif.retry_cnt), MAX_RETRY);
        repeat (1000) tick();
        chk("fault_sticky_state", int'(bif.state_mon), S_FAULT);

        // Restart out of FAULT
        pulse_restart();
        chk("fault_restart_state", int'(bif.state_mon), S_IDLE);
        chk("fault_restart_retry", int'(bif.retry_cnt), 0);
        chk("fault_restart_fault", int'(bif.fault), 0);

        // Restart coinciding with a PLL_WAIT timeout (retry already 1)
        wait_state(S_PLL_WAIT, 20, "coinc_reach_pll_wait");
        time_in_state(S_PLL_WAIT, 40, n);
        chk("coinc_first_retry", int'(bif.retry_cnt), 1);
        wait_state(S_PLL_WAIT, 20, "coinc_reach_pll_wait2");
        repeat (TIMEOUT - 1) tick();
        pulse_restart();
        chk("coinc_state", int'(bif.state_mon), S_IDLE);
        chk("coinc_retry", int'(bif.retry_cnt), 0);

        // reset_n pulse in the middle of the CPLL reset pulse
        wait_state(S_PLL_RST, 20, "midrst_reach_pll_rst");
        tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_cpll_reset", int'(bif.cpll_reset), 0);
        chk("midrst_state", int'(bif.state_mon), S_IDLE);
        reset_n = 1'b1;
        wait_state(S_PLL_WAIT, 20, "midrst_reach_pll_wait");
        chk("midrst_cpll_rise_cycle", rise_cyc, PLL_DELAY);
        chk("midrst_cpll_width", pulse_w, PULSE_LEN);

        // Random soak against the reference model
        for (int i = 0; i < 3000; i++) begin
            bit [3:0] st;
            reset_n     = ($urandom_range(0, 399) != 0);
            bif.restart = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 29) == 0) bif.cpll_locked = ~bif.cpll_locked;
            st = cur_st;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) st[b] = ~st[b];
            end
            set_status(st);
            tick();
        end

        reset_n = 1'b1;
        bif.restart = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
